// File: rtl/ad7324_responder.sv
// ad7324_responder
//   Converter end of an AD7324-style SPI link. CS, SCLK and DIN are
//   oversampled on CLK20M. Each 16-bit frame is answered on DOUT with
//   {1'b0, channel ID, 13-bit two's-complement sample}. Control-register
//   writes arriving on DIN select the channel and, optionally, a channel
//   sequence.
//
//   Optional feature: define AD7324_RESP_SEQ_EN to compile in the channel
//   sequencer (SEQ = 2'b11 walks CUR_CH 0..ADD). Without it CUR_CH = ADD.
//
// Ports
//   CLK20M       in   system clock (>= 8x SCLK)
//   RSTp         in   synchronous active-high reset
//   CS           in   chip select from master, active low, asynchronous
//   SCLK         in   serial clock from master, asynchronous
//   DIN          in   master-to-responder data
//   DOUT         out  responder-to-master data
//   DOUT_OE      out  DOUT drive enable (tri-state at top level when 0)
//   CH0..3_DATA  in   13-bit sample per channel
//   CUR_CH       out  channel converted at the next CS fall
//   CTRL_REG     out  last accepted control word [11:0]
//   FRAME_DONE   out  one-cycle pulse after a complete 16-edge frame
//   FRAME_ABORT  out  one-cycle pulse when CS rises mid-frame
//   FSM_STATE    out  debug view of the frame FSM (0 idle, 1 shift, 2 done)
module ad7324_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic        CLK20M,
  input  logic        RSTp,
  input  logic        CS,
  input  logic        SCLK,
  input  logic        DIN,
  output logic        DOUT,
  output logic        DOUT_OE,
  input  logic [12:0] CH0_DATA,
  input  logic [12:0] CH1_DATA,
  input  logic [12:0] CH2_DATA,
  input  logic [12:0] CH3_DATA,
  output logic [1:0]  CUR_CH,
  output logic [11:0] CTRL_REG,
  output logic        FRAME_DONE,
  output logic        FRAME_ABORT,
  output logic [1:0]  FSM_STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(FRAME_BITS - 1);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, din_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic [15:0]            tx_q, rx_q;
  logic [4:0]             cnt_q;
  logic                   dout_q, oe_q, done_q, abort_q;
  logic [1:0]             cur_q;
  logic [11:0]            ctrl_q;
`ifdef AD7324_RESP_SEQ_EN
  logic                   seq_on_q;
  logic                   seq_on_d;
`endif

  // Synchronized levels and single-cycle edge strobes
  logic cs_s, sclk_s, din_s;
  logic cs_fall, cs_rise, sclk_fall;
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  // Sample captured at the CS fall; the channel mux is only looked at then.
  logic [12:0] sample_d;
  logic [15:0] tx_load_d;
  always_comb begin
    sample_d = CH0_DATA;
    case (cur_q)
      2'd0: sample_d = CH0_DATA;
      2'd1: sample_d = CH1_DATA;
      2'd2: sample_d = CH2_DATA;
      2'd3: sample_d = CH3_DATA;
      default: sample_d = CH0_DATA;
    endcase
  end
  assign tx_load_d = {1'b0, cur_q, sample_d};

  // Frame-completion decode uses rx including the bit arriving on the 16th fall.
  logic [15:0] rx_d;
  logic        wr_ctrl_d;
  logic [11:0] ctrl_d;
  logic [1:0]  cur_d;
  logic        unused_rx_bit;
  assign rx_d          = {rx_q[14:0], din_s};
  assign wr_ctrl_d     = rx_d[15] && (rx_d[14:13] == 2'b00);
  assign ctrl_d        = wr_ctrl_d ? rx_d[11:0] : ctrl_q;
  assign unused_rx_bit = rx_d[12];

`ifdef AD7324_RESP_SEQ_EN
  assign seq_on_d = wr_ctrl_d ? (rx_d[4:3] == 2'b11) : seq_on_q;
  always_comb begin
    cur_d = ctrl_d[11:10];
    if (seq_on_d) begin
      if (wr_ctrl_d || (cur_q >= ctrl_d[11:10])) cur_d = 2'd0;
      else                                       cur_d = cur_q + 2'd1;
    end
  end
`else
  assign cur_d = ctrl_d[11:10];
`endif

  always_ff @(posedge CLK20M) begin
    if (RSTp) begin
      state_q     <= S_IDLE;
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      din_sync_q  <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      dout_q      <= 1'b0;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      cur_q       <= '0;
      ctrl_q      <= '0;
`ifdef AD7324_RESP_SEQ_EN
      seq_on_q    <= 1'b0;
`endif
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], DIN};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            tx_q    <= tx_load_d;
            dout_q  <= tx_load_d[15];
            oe_q    <= 1'b1;
            cnt_q   <= '0;
            rx_q    <= '0;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (sclk_fall && (cnt_q == LAST_CNT)) begin
            // 16th fall wins over a coincident CS rise: frame completes.
            rx_q   <= rx_d;
            tx_q   <= {tx_q[14:0], 1'b0};
            cnt_q  <= cnt_q + 5'd1;
            dout_q <= 1'b0;
            done_q <= 1'b1;
            ctrl_q <= ctrl_d;
            cur_q  <= cur_d;
`ifdef AD7324_RESP_SEQ_EN
            seq_on_q <= seq_on_d;
`endif
            if (cs_rise) begin
              oe_q    <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DONE;
            end
          end else if (cs_rise) begin
            abort_q <= 1'b1;
            oe_q    <= 1'b0;
            dout_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (sclk_fall) begin
            rx_q   <= rx_d;
            tx_q   <= {tx_q[14:0], 1'b0};
            cnt_q  <= cnt_q + 5'd1;
            dout_q <= tx_q[14];
          end
        end

        S_DONE: begin
          // A new CS fall takes priority if the rise was never seen.
          if (cs_fall) begin
            tx_q    <= tx_load_d;
            dout_q  <= tx_load_d[15];
            oe_q    <= 1'b1;
            cnt_q   <= '0;
            rx_q    <= '0;
            state_q <= S_SHIFT;
          end else if (cs_rise) begin
            oe_q    <= 1'b0;
            dout_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          oe_q    <= 1'b0;
          dout_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign DOUT        = dout_q;
  assign DOUT_OE     = oe_q;
  assign CUR_CH      = cur_q;
  assign CTRL_REG    = ctrl_q;
  assign FRAME_DONE  = done_q;
  assign FRAME_ABORT = abort_q;
  assign FSM_STATE   = state_q;

endmodule

// File: tb/tb_ad7324_responder.sv
// Directed bench for ad7324_responder: acts as the SPI master, reads frames
// and compares against hand-computed words and register values.
`timescale 1ns/1ps
module tb_ad7324_responder;

  logic        CLK20M = 1'b0;
  logic        RSTp   = 1'b1;
  logic        CS     = 1'b1;
  logic        SCLK   = 1'b1;
  logic        DIN    = 1'b0;
  logic        DOUT, DOUT_OE, FRAME_DONE, FRAME_ABORT;
  logic [12:0] CH0_DATA = 13'h1F9C;
  logic [12:0] CH1_DATA = 13'h0AAA;
  logic [12:0] CH2_DATA = 13'h0123;
  logic [12:0] CH3_DATA = 13'h1555;
  logic [1:0]  CUR_CH, FSM_STATE;
  logic [11:0] CTRL_REG;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  // clock / reset
  always #25 CLK20M = ~CLK20M;

  ad7324_responder dut (
    .CLK20M(CLK20M), .RSTp(RSTp), .CS(CS), .SCLK(SCLK), .DIN(DIN),
    .DOUT(DOUT), .DOUT_OE(DOUT_OE),
    .CH0_DATA(CH0_DATA), .CH1_DATA(CH1_DATA), .CH2_DATA(CH2_DATA), .CH3_DATA(CH3_DATA),
    .CUR_CH(CUR_CH), .CTRL_REG(CTRL_REG),
    .FRAME_DONE(FRAME_DONE), .FRAME_ABORT(FRAME_ABORT), .FSM_STATE(FSM_STATE)
  );

  always @(negedge CLK20M) begin
    if (FRAME_DONE)  done_cnt++;
    if (FRAME_ABORT) abort_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK20M);
  endtask

  // Expected read word for a channel, built from the bench's own sample values.
  function automatic logic [15:0] word_of(input logic [1:0] ch);
    logic [12:0] s;
    case (ch)
      2'd0: s = 13'h1F9C;
      2'd1: s = 13'h0AAA;
      2'd2: s = 13'h0123;
      default: s = 13'h1555;
    endcase
    return {1'b0, ch, s};
  endfunction

  // driver: one CS-low window with nfall SCLK falls; DIN carries din_w MSB
  // first, then 1s for any extra edges.
  task automatic run_frame(input logic [15:0] din_w, input int nfall, output logic [15:0] rd);
    rd = '0;
    CS = 1'b0;
    wait_clk(12);
    check("oe_in_frame", 16'(DOUT_OE), 16'h1);
    for (int i = 0; i < nfall; i++) begin
      if (i < 16) rd[15-i] = DOUT;
      else        check("dout_after_16", 16'(DOUT), 16'h0);
      DIN = (i < 16) ? din_w[15-i] : 1'b1;
      wait_clk(4);
      SCLK = 1'b0;
      wait_clk(8);
      SCLK = 1'b1;
      wait_clk(4);
    end
    CS = 1'b1;
    wait_clk(12);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [1:0]  exp_ch;
    logic [1:0]  exp_cur;
    int d0, a0;

    wait_clk(5);
    RSTp = 1'b0;
    wait_clk(2);
    check("rst_dout",  16'(DOUT), 16'h0);
    check("rst_oe",    16'(DOUT_OE), 16'h0);
    check("rst_cur",   16'(CUR_CH), 16'h0);
    check("rst_ctrl",  16'(CTRL_REG), 16'h0);
    check("rst_state", 16'(FSM_STATE), 16'h0);
    wait_clk(10);

    // Reset read
    d0 = done_cnt;
    run_frame(16'h0000, 16, rd);
    check("read_ch0", rd, 16'h1F9C);
    check("read_ch0_done", 16'(done_cnt - d0), 16'h1);
    check("read_ch0_cur", 16'(CUR_CH), 16'h0);
    check("idle_oe", 16'(DOUT_OE), 16'h0);

    // Channel select
    run_frame(16'h8800, 16, rd);
    check("wr8800_read", rd, word_of(2'd0));
    check("wr8800_ctrl", 16'(CTRL_REG), 16'h0800);
    check("wr8800_cur",  16'(CUR_CH), 16'h2);
    run_frame(16'h0000, 16, rd);
    check("read_ch2", rd, 16'h4123);

    // Sequencer
    run_frame(16'h8C18, 16, rd);
    check("wr8c18_read", rd, 16'h4123);
    check("wr8c18_ctrl", 16'(CTRL_REG), 16'h0C18);
    for (int i = 0; i < 5; i++) begin
`ifdef AD7324_RESP_SEQ_EN
      exp_ch = 2'(i % 4);
`else
      exp_ch = 2'd3;
`endif
      run_frame(16'h0000, 16, rd);
      check($sformatf("seq_frame%0d", i), rd, word_of(exp_ch));
    end
`ifdef AD7324_RESP_SEQ_EN
    exp_cur = 2'd1;
`else
    exp_cur = 2'd3;
`endif
    check("seq_cur_after", 16'(CUR_CH), 16'(exp_cur));

    // Abort after 7 falls
    d0 = done_cnt;
    a0 = abort_cnt;
    run_frame(16'hFFFF, 7, rd);
    check("abort_pulse", 16'(abort_cnt - a0), 16'h1);
    check("abort_no_done", 16'(done_cnt - d0), 16'h0);
    check("abort_ctrl", 16'(CTRL_REG), 16'h0C18);
    check("abort_cur", 16'(CUR_CH), 16'(exp_cur));
    check("abort_oe", 16'(DOUT_OE), 16'h0);
    check("abort_state", 16'(FSM_STATE), 16'h0);

    // Reset mid-frame after 9 bits
    CS = 1'b0;
    wait_clk(12);
    for (int i = 0; i < 9; i++) begin
      DIN = 1'b1;
      wait_clk(4);
      SCLK = 1'b0;
      wait_clk(8);
      SCLK = 1'b1;
      wait_clk(4);
    end
    RSTp = 1'b1;
    wait_clk(1);
    RSTp = 1'b0;
    check("midrst_dout",  16'(DOUT), 16'h0);
    check("midrst_oe",    16'(DOUT_OE), 16'h0);
    check("midrst_cur",   16'(CUR_CH), 16'h0);
    check("midrst_ctrl",  16'(CTRL_REG), 16'h0);
    check("midrst_done",  16'(FRAME_DONE), 16'h0);
    check("midrst_abort", 16'(FRAME_ABORT), 16'h0);
    CS = 1'b1;
    DIN = 1'b0;
    wait_clk(12);
    run_frame(16'h0000, 16, rd);
    check("post_rst_read", rd, 16'h1F9C);

    // Extra edges: 20 falls, only first 16 DIN bits count
    d0 = done_cnt;
    run_frame(16'h8400, 20, rd);
    check("extra_read", rd, 16'h1F9C);
    check("extra_done", 16'(done_cnt - d0), 16'h1);
    check("extra_ctrl", 16'(CTRL_REG), 16'h0400);
    check("extra_cur",  16'(CUR_CH), 16'h1);
    run_frame(16'h0000, 16, rd);
    check("read_ch1", rd, 16'h2AAA);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
